// File: rtl/sensor_capture_buf_if.sv
// Handshake and status bundle shared by the SCtrl wrapper, the sensor and the capture buffer.
// The buffer sits on the slave modport; the wrapper/sensor side uses master.
interface sensor_capture_buf_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic          sctrl_en;
  logic          sctrl_clear;
  logic [AW-1:0] sctrl_addr;
  logic [DW-1:0] sctrl_out;
  logic          sctrl_interrupt;
  logic [AW:0]   sctrl_count;
  logic          sctrl_ovf;
  logic          sensor_en;
  logic          sensor_ready;
  logic [DW-1:0] sensor_out;

  modport master (
    output sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    input  sctrl_out, sctrl_interrupt, sctrl_count, sctrl_ovf, sensor_en
  );

  modport slave (
    input  sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
    output sctrl_out, sctrl_interrupt, sctrl_count, sctrl_ovf, sensor_en
  );
endinterface

// File: rtl/sensor_capture_buf.sv
// Sensor capture buffer: collects DEPTH samples from the sensor while enabled,
// raises an interrupt when full and serves combinational word reads to the wrapper.
module sensor_capture_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input logic                  clk,
  input logic                  resetn,
  sensor_capture_buf_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam logic [AW:0] CNT_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;
  logic          sensor_en_q;
  logic          irq_q;
  logic          ovf_q;
  logic          wr_en;
  logic [DW-1:0] mem [DEPTH];

  // Clear (and reset) drop a sample arriving in the same cycle.
  assign wr_en = resetn && !bus.sctrl_clear && (state == CAPTURE) && bus.sensor_ready;

  // Sample storage; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= bus.sensor_out;
  end

  // Read port: zero latency, a same-cycle write is not yet visible.
  assign bus.sctrl_out       = mem[bus.sctrl_addr];
  assign bus.sctrl_count     = count;
  assign bus.sctrl_interrupt = irq_q;
  assign bus.sctrl_ovf       = ovf_q;
  assign bus.sensor_en       = sensor_en_q;

  // Control FSM with registered status outputs; reset > clear > transitions.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      wptr        <= '0;
      count       <= '0;
      sensor_en_q <= 1'b0;
      irq_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (bus.sctrl_clear) begin
      state       <= IDLE;
      wptr        <= '0;
      count       <= '0;
      sensor_en_q <= 1'b0;
      irq_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sctrl_en && (count < CNT_MAX)) begin
            state       <= CAPTURE;
            sensor_en_q <= 1'b1;
          end
        end
        CAPTURE: begin
          if (bus.sensor_ready) begin
            wptr  <= wptr + 1'b1;
            count <= count + 1'b1;
            if (count == CNT_LAST) begin
              state       <= FULL;
              sensor_en_q <= 1'b0;
              irq_q       <= 1'b1;
            end else if (!bus.sctrl_en) begin
              state       <= IDLE;
              sensor_en_q <= 1'b0;
            end
          end else if (!bus.sctrl_en) begin
            state       <= IDLE;
            sensor_en_q <= 1'b0;
          end
        end
        FULL: begin
          if (bus.sensor_ready) ovf_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          sensor_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
